// File: rtl/processor_pkg.sv
// Shared processor definitions: reset constants, fetch-state encoding and
// the next-PC selection rule used by the instruction fetch unit.
package processor_pkg;

  localparam logic [15:0] RESET_VECTOR = 16'h0000;
  localparam logic [15:0] INSTR_NOP    = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } fetch_state_t;

  // Jump beats branch beats sequential; all arithmetic wraps at 16 bits.
  function automatic logic [15:0] next_pc(
    input logic [15:0] cur_pc,
    input logic        jump_en,
    input logic [15:0] jump_target,
    input logic        branch_mux,
    input logic [7:0]  branch_disp
  );
    logic [15:0] pc_inc;
    pc_inc = cur_pc + 16'd1;
    if (jump_en)
      return jump_target;
    if (branch_mux)
      return pc_inc + {{8{branch_disp[7]}}, branch_disp};
    return pc_inc;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-word reads on memory
// port A and latches the returned instruction one cycle later.
module instruction_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchReq,
  input  logic        pcEnabled,
  input  logic        branchMux,
  input  logic [7:0]  branchDisp,
  input  logic        jumpEn,
  input  logic [15:0] jumpTarget,
  input  logic [15:0] memData,
  output logic [15:0] memAddr,
  output logic        memEn,
  output logic [15:0] instruction,
  output logic        instrValid,
  output logic [15:0] pc,
  output logic [15:0] pcPlusOne,
  output logic        busy
);

  import processor_pkg::*;

  fetch_state_t state;
  fetch_state_t state_next;
  logic [15:0]  pc_target;
  logic [15:0]  pending_pc;
  logic         pending_valid;

  assign pc_target = next_pc(pc, jumpEn, jumpTarget, branchMux, branchDisp);
  assign memAddr   = pc;
  assign pcPlusOne = pc + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetchReq) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    memEn = 1'b0;
    busy  = 1'b0;
    case (state)
      ISSUE: begin
        memEn = 1'b1;
        busy  = 1'b1;
      end
      CAPTURE: busy = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the pending register is reset along with the PC so a fetch aborted
  // by reset can never leak a stale redirect into the next run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      pending_pc    <= RESET_VECTOR;
      pending_valid <= 1'b0;
      instruction   <= INSTR_NOP;
      instrValid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pcEnabled)
            pc <= pc_target;
          if (fetchReq)
            instrValid <= 1'b0;
        end
        ISSUE: begin
          if (pcEnabled) begin
            pending_pc    <= pc_target;
            pending_valid <= 1'b1;
          end
        end
        CAPTURE: begin
          instruction   <= memData;
          instrValid    <= 1'b1;
          pending_valid <= 1'b0;
          // A redirect arriving now overwrites the pending one and is
          // committed on this same edge, so it goes straight into pc.
          if (pcEnabled)
            pc <= pc_target;
          else if (pending_valid)
            pc <= pending_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: PC-arithmetic vector table,
// hand-written fetch/reset sequences, and randomized traffic against a model.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        reset;
  logic        fetchReq;
  logic        pcEnabled;
  logic        branchMux;
  logic [7:0]  branchDisp;
  logic        jumpEn;
  logic [15:0] jumpTarget;
  logic [15:0] memData;
  logic [15:0] memAddr;
  logic        memEn;
  logic [15:0] instruction;
  logic        instrValid;
  logic [15:0] pc;
  logic [15:0] pcPlusOne;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .fetchReq    (fetchReq),
    .pcEnabled   (pcEnabled),
    .branchMux   (branchMux),
    .branchDisp  (branchDisp),
    .jumpEn      (jumpEn),
    .jumpTarget  (jumpTarget),
    .memData     (memData),
    .memAddr     (memAddr),
    .memEn       (memEn),
    .instruction (instruction),
    .instrValid  (instrValid),
    .pc          (pc),
    .pcPlusOne   (pcPlusOne),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000)
      return 16'h0512;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Synchronous-read memory: data appears the cycle after memEn.
  initial memData = 16'h0000;
  always @(posedge clock)
    if (memEn) memData <= mem_word(memAddr);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fetchReq   = 1'b0;
    pcEnabled  = 1'b0;
    branchMux  = 1'b0;
    branchDisp = 8'h00;
    jumpEn     = 1'b0;
    jumpTarget = 16'h0000;
  endtask

  task automatic set_pc(input logic [15:0] value);
    pcEnabled  = 1'b1;
    jumpEn     = 1'b1;
    jumpTarget = value;
    tick();
    idle_inputs();
  endtask

  typedef struct {
    logic [15:0] start_pc;
    logic        jump_en;
    logic        branch_mux;
    logic [7:0]  disp;
    logic [15:0] jump_target;
    logic [15:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs[10];

  // Reference model state: phase 0 idle, 1 issuing, 2 capturing.
  int          m_phase;
  logic [15:0] m_pc;
  logic [15:0] m_fetch_addr;
  logic [15:0] m_instr;
  logic        m_valid;
  logic [15:0] m_pending[$];

  function automatic logic [15:0] model_target();
    int t;
    if (jumpEn)
      return jumpTarget;
    t = int'(m_pc) + 1;
    if (branchMux)
      t = t + int'($signed(branchDisp));
    return 16'(t);
  endfunction

  task automatic model_edge();
    logic [15:0] tgt;
    tgt = model_target();
    if (m_phase == 0) begin
      if (pcEnabled) m_pc = tgt;
      if (fetchReq) begin
        m_phase      = 1;
        m_valid      = 1'b0;
        m_fetch_addr = m_pc;
      end
    end else if (m_phase == 1) begin
      if (pcEnabled) begin
        m_pending.delete();
        m_pending.push_back(tgt);
      end
      m_phase = 2;
    end else begin
      m_instr = mem_word(m_fetch_addr);
      m_valid = 1'b1;
      if (pcEnabled) begin
        m_pending.delete();
        m_pending.push_back(tgt);
      end
      if (m_pending.size() > 0)
        m_pc = m_pending.pop_front();
      m_phase = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] addrs[$];
    int          en_count;
    logic        prev_en;
    logic        back_to_back;

    vecs[0] = '{16'h0010, 1'b0, 1'b1, 8'hFC, 16'h0000, 16'h000D};
    vecs[1] = '{16'h0010, 1'b0, 1'b1, 8'h05, 16'h0000, 16'h0016};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000};
    vecs[3] = '{16'hFFFF, 1'b1, 1'b1, 8'h05, 16'h1234, 16'h1234};
    vecs[4] = '{16'h0000, 1'b0, 1'b1, 8'h80, 16'h0000, 16'hFF81};
    vecs[5] = '{16'hFFFE, 1'b0, 1'b1, 8'h7F, 16'h0000, 16'h007E};
    vecs[6] = '{16'h0005, 1'b0, 1'b0, 8'h33, 16'hBEEF, 16'h0006};
    vecs[7] = '{16'h0100, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000};
    vecs[8] = '{16'hABCD, 1'b0, 1'b1, 8'h00, 16'h0000, 16'hABCE};
    vecs[9] = '{16'h0000, 1'b0, 1'b1, 8'hFE, 16'h0000, 16'hFFFF};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("reset pc", pc, 16'h0000);
    check("reset pcPlusOne", pcPlusOne, 16'h0001);
    check("reset instruction", instruction, 16'h0000);
    check("reset instrValid", 16'(instrValid), 16'h0000);
    check("reset memEn", 16'(memEn), 16'h0000);
    check("reset busy", 16'(busy), 16'h0000);
    reset = 1'b0;

    // First fetch after reset reads word 0.
    fetchReq = 1'b1;
    tick();
    fetchReq = 1'b0;
    check("issue memEn", 16'(memEn), 16'h0001);
    check("issue memAddr", memAddr, 16'h0000);
    check("issue busy", 16'(busy), 16'h0001);
    tick();
    check("capture memEn", 16'(memEn), 16'h0000);
    check("capture instrValid", 16'(instrValid), 16'h0000);
    tick();
    check("fetch0 instruction", instruction, 16'h0512);
    check("fetch0 instrValid", 16'(instrValid), 16'h0001);
    check("fetch0 busy", 16'(busy), 16'h0000);

    foreach (vecs[i]) begin
      set_pc(vecs[i].start_pc);
      pcEnabled  = 1'b1;
      jumpEn     = vecs[i].jump_en;
      branchMux  = vecs[i].branch_mux;
      branchDisp = vecs[i].disp;
      jumpTarget = vecs[i].jump_target;
      tick();
      idle_inputs();
      check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d pcPlusOne", i), pcPlusOne, vecs[i].exp_pc + 16'd1);
    end

    // Redirect during ISSUE is deferred until the fetch completes.
    set_pc(16'h0020);
    fetchReq = 1'b1;
    tick();
    fetchReq  = 1'b0;
    pcEnabled = 1'b1;
    check("deferred memAddr", memAddr, 16'h0020);
    tick();
    pcEnabled = 1'b0;
    check("deferred pc held", pc, 16'h0020);
    tick();
    check("deferred pc commit", pc, 16'h0021);
    check("deferred instruction", instruction, mem_word(16'h0020));

    // Two redirects in one fetch: the later one wins.
    fetchReq = 1'b1;
    tick();
    fetchReq = 1'b0;
    pcEnabled = 1'b1; jumpEn = 1'b1; jumpTarget = 16'h0300;
    tick();
    jumpTarget = 16'h0400;
    check("last-wins pc held", pc, 16'h0021);
    tick();
    idle_inputs();
    check("last-wins pc", pc, 16'h0400);

    // Reset in CAPTURE clears outputs without a clock edge.
    fetchReq = 1'b1;
    tick();
    fetchReq = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    check("abort instrValid", 16'(instrValid), 16'h0000);
    check("abort instruction", instruction, 16'h0000);
    check("abort pc", pc, 16'h0000);
    check("abort busy", 16'(busy), 16'h0000);
    #1 reset = 1'b0;
    tick();
    check("abort discard instruction", instruction, 16'h0000);
    check("abort discard instrValid", 16'(instrValid), 16'h0000);
    fetchReq = 1'b1;
    tick();
    fetchReq = 1'b0;
    check("post-reset memAddr", memAddr, 16'h0000);
    tick();
    tick();
    check("post-reset instruction", instruction, 16'h0512);

    // fetchReq held for six edges: two fetches, never back-to-back reads.
    set_pc(16'h0040);
    en_count = 0;
    prev_en = 1'b0;
    back_to_back = 1'b0;
    fetchReq = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c == 5) fetchReq = 1'b0;
      pcEnabled = (c == 0);
      if (memEn) begin
        en_count++;
        addrs.push_back(memAddr);
        if (prev_en) back_to_back = 1'b1;
      end
      prev_en = memEn;
    end
    idle_inputs();
    check("held fetch count", 16'(en_count), 16'd2);
    check("held back-to-back", 16'(back_to_back), 16'h0000);
    if (addrs.size() >= 2) begin
      check("held addr0", addrs[0], 16'h0040);
      check("held addr1", addrs[1], 16'h0041);
    end else begin
      check("held addr count", 16'(addrs.size()), 16'd2);
    end

    // Randomized traffic against the reference model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_phase = 0; m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0;
    m_fetch_addr = 16'h0000;
    m_pending.delete();
    for (int i = 0; i < 500; i++) begin
      fetchReq   = ($urandom_range(1) == 1);
      pcEnabled  = ($urandom_range(9) < 3);
      jumpEn     = ($urandom_range(3) == 0);
      branchMux  = ($urandom_range(1) == 1);
      branchDisp = 8'($urandom);
      jumpTarget = 16'($urandom);
      tick();
      model_edge();
      check("rand pc", pc, m_pc);
      check("rand pcPlusOne", pcPlusOne, m_pc + 16'd1);
      check("rand memEn", 16'(memEn), 16'(m_phase == 1));
      check("rand busy", 16'(busy), 16'(m_phase != 0));
      check("rand instrValid", 16'(instrValid), 16'(m_valid));
      check("rand instruction", instruction, m_instr);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
